jt900h_shift_seq: RTL and testbench
===================================

# jt900h_shift_seq

Iterative shift/rotate engine for the TLCS-900H core, sitting beside the ALU on the operand bus and feeding the register write-back mux. The ALU only does a single-bit right shift per pass. This block executes the full RLC/RRC/RL/RR/SLA/SRA/SLL/SRL family with a count of 1–16, one bit per enabled cycle, and produces the result plus the flag set for the status register.

## Interface
Parameters:
- none. Width is fixed at 32 bits; operand size is selected per operation.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset (low = reset).
- `cen`  in  1  clock enable; all state advances only when high.
- `start`  in  1  request a new operation; sampled with `cen`.
- `op`  in  3  0 RLC, 1 RRC, 2 RL, 3 RR, 4 SLA, 5 SRA, 6 SLL, 7 SRL.
- `bs`, `ws`  in  1 each  byte / word size; both low = long. `bs` has priority.
- `cnt`  in  4  shift count; 0 means 16.
- `op0`  in  32  operand.
- `cin`  in  1  carry flag in, used by RL/RR.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-`cen`-cycle pulse when the result is valid.
- `rslt`  out  32  result; held until the next accepted `start`.
- `c`, `z`, `n`, `v`  out  1 each  carry, zero, sign, parity (1 = even).

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start & cen` latches `op`, size, `cin` and the operand into the working register. The 5-bit counter is loaded with `cnt`, or 16 if `cnt` is 0.
  - Goes to RUN with `busy`=1.
- RUN: each `cen` cycle performs one bit step on the active width W (8/16/32) and decrements the counter. At count 1 the last step is taken and the state moves to DONE.
  - RLC: msb→lsb, C=msb.
  - RRC: lsb→msb, C=lsb.
  - RL: C→lsb, C=msb.
  - RR: C→msb, C=lsb.
  - SLA and SLL: 0→lsb, C=msb.
  - SRA: msb kept, C=lsb.
  - SRL: 0→msb, C=lsb.
- DONE:
  - Asserts `done` for one `cen` cycle.
  - `busy`=0.
  - `rslt` and flags are registered.
  - Returns to IDLE.
- Bits above W keep their `op0` values in `rslt`.
- Flags:
  - `c` is the last bit shifted out, or the rotated bit for RLC/RRC.
  - `z` = active W bits all zero.
  - `n` = bit W-1.
  - `v` = even parity over the active W bits.
- `start` while `busy` is ignored; there is no queueing.
- `start` in DONE is ignored; it is accepted from IDLE on the next cycle.

## Timing
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0.
  - `rslt`=0.
  - `c`=`z`=`n`=`v`=0.
- Latency is N+1 `cen` cycles from the start edge to `done`, where N is the count (1–16).
  - `busy` is high for N cycles.
  - `done` is high in cycle N+1.
- `cen` low freezes the state, counter, working register and outputs. A `done` pulse stretches across `cen`-low cycles until the next `cen`-high edge.
- Reset asserted mid-operation aborts immediately to the reset values. There are no partial results.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared include `jt900h.inc` defines the 3-bit shift-opcode localparams (RLC..SRL) and the size encoding, so the decoder and this block agree.
- Natural sub-module: `jt900h_shift_step`.
  - Combinational one-bit step.
  - Inputs: value, op, size, carry.
  - Outputs: next value, next carry.
  - Upper-bit preservation is handled inside the step.
- The sequencer owns the FSM, counter and flag generation.

## Test plan
- RLC byte, `op0`=0x12345681, `cnt`=1 → `rslt`=0x12345603, `c`=1, `z`=0, `n`=0, `v`=1; `done` 2 cycles after start.
- SRA word, `op0`=0x00008000, `cnt`=15 → `rslt`=0x0000FFFF, `c`=0, `n`=1, `v`=1; `busy` high for 15 cycles.
- SRL long, `op0`=0x00000001, `cnt`=0 (16 steps) → `rslt`=0, `c`=0, `z`=1; `done` at cycle 17.
- RL byte, `op0`=0x00, `cin`=1, `cnt`=3 → `rslt`=0x04, `c`=0.
- RR byte, `op0`=0x01, `cin`=0, `cnt`=1 → `rslt`=0x00, `c`=1, `z`=1, `v`=1.
- Control and abort:
  - Second `start` while busy → ignored; the first result is unchanged.
  - `cen` held low for 5 cycles mid-run → latency grows by exactly 5.
  - `rst` low during RUN → `busy`=0 and `rslt`=0 immediately; the next start runs normally.

Source files
------------

// File: rtl/jt900h_shift_seq_pkg.sv
// Shared shift-opcode and operand-size encodings for the TLCS-900H shift sequencer
// and its decoder, plus small width helpers.
package jt900h_shift_seq_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        OP_RLC = 3'd0,
        OP_RRC = 3'd1,
        OP_RL  = 3'd2,
        OP_RR  = 3'd3,
        OP_SLA = 3'd4,
        OP_SRA = 3'd5,
        OP_SLL = 3'd6,
        OP_SRL = 3'd7
    } shift_op_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_WORD = 2'd1,
        SZ_LONG = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // bs wins over ws; neither set selects a 32-bit operand
    function automatic size_e decode_size(input logic bs, input logic ws);
        if (bs)
            return SZ_BYTE;
        else if (ws)
            return SZ_WORD;
        else
            return SZ_LONG;
    endfunction

    function automatic logic [DATA_W-1:0] size_mask(input size_e sz);
        case (sz)
            SZ_BYTE: return 32'h0000_00FF;
            SZ_WORD: return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [4:0] msb_index(input size_e sz);
        case (sz)
            SZ_BYTE: return 5'd7;
            SZ_WORD: return 5'd15;
            default: return 5'd31;
        endcase
    endfunction

    // even opcodes move bits towards the msb
    function automatic logic is_left(input shift_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/jt900h_shift_seq_if.sv
// Operand/result bus between the instruction sequencer and the shift engine.
interface jt900h_shift_seq_if;

    logic        start;
    logic [2:0]  op;
    logic        bs;
    logic        ws;
    logic [3:0]  cnt;
    logic [31:0] op0;
    logic        cin;

    logic        busy;
    logic        done;
    logic [31:0] rslt;
    logic        c;
    logic        z;
    logic        n;
    logic        v;

    modport master (
        output start, op, bs, ws, cnt, op0, cin,
        input  busy, done, rslt, c, z, n, v
    );

    modport slave (
        input  start, op, bs, ws, cnt, op0, cin,
        output busy, done, rslt, c, z, n, v
    );

endinterface

// File: rtl/jt900h_shift_step.sv
// Combinational single-bit shift/rotate on the active operand width; bits above
// the active width pass through untouched.
module jt900h_shift_step
    import jt900h_shift_seq_pkg::*;
(
    input  logic [31:0] value,
    input  shift_op_e   op,
    input  size_e       size,
    input  logic        carry,
    output logic [31:0] next_value,
    output logic        next_carry
);

    logic [4:0]  msb_idx;
    logic [31:0] mask;
    logic        msb;
    logic        lsb;
    logic        fill_l;
    logic        fill_r;
    logic [31:0] shl;
    logic [31:0] shr;

    assign msb_idx = msb_index(size);
    assign mask    = size_mask(size);
    assign msb     = value[msb_idx];
    assign lsb     = value[0];

    always_comb begin
        fill_l = 1'b0;
        fill_r = 1'b0;
        case (op)
            OP_RLC:  fill_l = msb;
            OP_RL:   fill_l = carry;
            OP_RRC:  fill_r = lsb;
            OP_RR:   fill_r = carry;
            OP_SRA:  fill_r = msb;
            default: begin
                fill_l = 1'b0;
                fill_r = 1'b0;
            end
        endcase
    end

    assign shl = {value[30:0], fill_l};

    // right shift injects the fill bit at the active msb rather than bit 31
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_shr
            if (gi == 31) begin : g_top
                assign shr[gi] = (msb_idx == 5'(gi)) ? fill_r : 1'b0;
            end else begin : g_mid
                assign shr[gi] = (msb_idx == 5'(gi)) ? fill_r : value[gi+1];
            end
        end
    endgenerate

    assign next_value = ((is_left(op) ? shl : shr) & mask) | (value & ~mask);
    assign next_carry = is_left(op) ? msb : lsb;

endmodule

// File: rtl/jt900h_shift_seq.sv
// Iterative shift/rotate engine: one bit per enabled cycle, count 1..16, with
// registered result and C/Z/N/V flags.
module jt900h_shift_seq
    import jt900h_shift_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    jt900h_shift_seq_if.slave bus
);

    state_e      state_reg;
    shift_op_e   op_reg;
    size_e       size_reg;
    logic [31:0] work_reg;
    logic        carry_reg;
    logic [4:0]  count_reg;

    logic        busy_reg;
    logic        done_reg;
    logic [31:0] rslt_reg;
    logic        c_reg;
    logic        z_reg;
    logic        n_reg;
    logic        v_reg;

    logic [31:0] step_value;
    logic        step_carry;
    logic [31:0] active_bits;
    logic        flag_z;
    logic        flag_n;
    logic        flag_v;

    jt900h_shift_step u_step (
        .value      (work_reg),
        .op         (op_reg),
        .size       (size_reg),
        .carry      (carry_reg),
        .next_value (step_value),
        .next_carry (step_carry)
    );

    // bits outside the active width are masked so they cannot disturb Z or parity
    assign active_bits = work_reg & size_mask(size_reg);
    assign flag_z      = (active_bits == 32'd0);
    assign flag_n      = work_reg[msb_index(size_reg)];
    assign flag_v      = ~^active_bits;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            op_reg    <= OP_RLC;
            size_reg  <= SZ_BYTE;
            work_reg  <= 32'd0;
            carry_reg <= 1'b0;
            count_reg <= 5'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            rslt_reg  <= 32'd0;
            c_reg     <= 1'b0;
            z_reg     <= 1'b0;
            n_reg     <= 1'b0;
            v_reg     <= 1'b0;
        end else if (cen) begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_reg    <= shift_op_e'(bus.op);
                        size_reg  <= decode_size(bus.bs, bus.ws);
                        work_reg  <= bus.op0;
                        carry_reg <= bus.cin;
                        count_reg <= (bus.cnt == 4'd0) ? 5'd16 : {1'b0, bus.cnt};
                        busy_reg  <= 1'b1;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    work_reg  <= step_value;
                    carry_reg <= step_carry;
                    count_reg <= count_reg - 5'd1;
                    if (count_reg == 5'd1) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b1;
                    rslt_reg  <= work_reg;
                    c_reg     <= carry_reg;
                    z_reg     <= flag_z;
                    n_reg     <= flag_n;
                    v_reg     <= flag_v;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.rslt = rslt_reg;
    assign bus.c    = c_reg;
    assign bus.z    = z_reg;
    assign bus.n    = n_reg;
    assign bus.v    = v_reg;

endmodule

// File: tb/tb_jt900h_shift_seq.sv
// Bench for jt900h_shift_seq: directed vector table, random ops against an
// arithmetic reference model, and control/abort sequences.
module tb_jt900h_shift_seq;

    typedef struct packed {
        logic [31:0] rslt;
        logic        c;
        logic        z;
        logic        n;
        logic        v;
    } res_t;

    typedef struct {
        logic [2:0]  op;
        logic        bs;
        logic        ws;
        logic [3:0]  cnt;
        logic [31:0] op0;
        logic        cin;
        res_t        exp;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cen = 1'b1;
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    always #5 clk = ~clk;

    jt900h_shift_seq_if sh ();

    jt900h_shift_seq dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .bus (sh.slave)
    );

    // Reference: whole-operation arithmetic on the W-bit field (rotates through a
    // W+1-bit value for RL/RR), not a bit-by-bit replay.
    function automatic res_t model(input logic [2:0] o, input logic b, input logic w,
                                   input logic [3:0] k4, input logic [31:0] x, input logic ci);
        res_t r;
        int wd, k, s;
        longint unsigned m, xv, t, tm, y, sx;
        logic cc;
        wd = b ? 8 : (w ? 16 : 32);
        k  = (k4 == 4'd0) ? 16 : int'(k4);
        m  = (64'd1 << wd) - 64'd1;
        xv = {32'd0, x} & m;
        tm = (64'd1 << (wd + 1)) - 64'd1;
        t  = xv | ({63'd0, ci} << wd);
        y  = 64'd0;
        cc = 1'b0;
        case (o)
            3'd0: begin
                s  = k % wd;
                y  = ((xv << s) | (xv >> (wd - s))) & m;
                cc = y[0];
            end
            3'd1: begin
                s  = k % wd;
                y  = ((xv >> s) | (xv << (wd - s))) & m;
                cc = y[wd-1];
            end
            3'd2: begin
                s  = k % (wd + 1);
                t  = ((t << s) | (t >> (wd + 1 - s))) & tm;
                y  = t & m;
                cc = t[wd];
            end
            3'd3: begin
                s  = k % (wd + 1);
                t  = ((t >> s) | (t << (wd + 1 - s))) & tm;
                y  = t & m;
                cc = t[wd];
            end
            3'd4, 3'd6: begin
                t  = xv << k;
                y  = t & m;
                cc = t[wd];
            end
            3'd5: begin
                sx = xv[wd-1] ? (xv | ~m) : xv;
                y  = $signed(sx) >>> k;
                y  = y & m;
                cc = sx[k-1];
            end
            default: begin
                y  = xv >> k;
                cc = xv[k-1];
            end
        endcase
        r.rslt = (x & ~m[31:0]) | y[31:0];
        r.c    = cc;
        r.z    = (y == 64'd0);
        r.n    = y[wd-1];
        r.v    = ($countones(y) % 2) == 0;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic start_op(input logic [2:0] o, input logic b, input logic w,
                            input logic [3:0] k, input logic [31:0] x, input logic ci);
        @(negedge clk);
        sh.op    = o;
        sh.bs    = b;
        sh.ws    = w;
        sh.cnt   = k;
        sh.op0   = x;
        sh.cin   = ci;
        sh.start = 1'b1;
        @(negedge clk);
        sh.start = 1'b0;
    endtask

    // lat counts clock edges after the accepting edge; bounded so a stuck DUT still ends
    task automatic wait_done(input int lat_in, output int lat, output int bcyc);
        lat  = lat_in;
        bcyc = 0;
        while (!sh.done && lat <= 60) begin
            if (sh.busy)
                bcyc++;
            @(negedge clk);
            lat++;
        end
        if (!sh.done)
            check("done_timeout", 32'(lat), 32'd0);
    endtask

    task automatic check_res(input string tag, input res_t e);
        check({tag, "_rslt"}, sh.rslt, e.rslt);
        check({tag, "_c"}, {31'd0, sh.c}, {31'd0, e.c});
        check({tag, "_z"}, {31'd0, sh.z}, {31'd0, e.z});
        check({tag, "_n"}, {31'd0, sh.n}, {31'd0, e.n});
        check({tag, "_v"}, {31'd0, sh.v}, {31'd0, e.v});
    endtask

    task automatic run_op(input logic [2:0] o, input logic b, input logic w,
                          input logic [3:0] k, input logic [31:0] x, input logic ci,
                          input res_t e, input int exp_lat);
        int lat, bcyc;
        start_op(o, b, w, k, x, ci);
        wait_done(0, lat, bcyc);
        $display("op=%0d bs=%0d ws=%0d cnt=%0d op0=%08h cin=%0d -> rslt=%08h c=%0d z=%0d n=%0d v=%0d lat=%0d busy=%0d",
                 o, b, w, k, x, ci, sh.rslt, sh.c, sh.z, sh.n, sh.v, lat, bcyc);
        check_res("op", e);
        check("latency", 32'(lat), 32'(exp_lat));
        check("busy_cycles", 32'(bcyc), 32'(exp_lat - 1));
        @(negedge clk);
        check("done_pulse", {31'd0, sh.done}, 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        int   lat, bcyc;
        res_t e;
        logic [2:0]  ro;
        logic        rb, rw, rci;
        logic [3:0]  rk;
        logic [31:0] rx;

        sh.start = 1'b0;
        sh.op    = 3'd0;
        sh.bs    = 1'b0;
        sh.ws    = 1'b0;
        sh.cnt   = 4'd0;
        sh.op0   = 32'd0;
        sh.cin   = 1'b0;

        vecs[0] = '{3'd0, 1'b1, 1'b0, 4'd1,  32'h1234_5681, 1'b0, '{32'h1234_5603, 1'b1, 1'b0, 1'b0, 1'b1}, 2};
        vecs[1] = '{3'd5, 1'b0, 1'b1, 4'd15, 32'h0000_8000, 1'b0, '{32'h0000_FFFF, 1'b0, 1'b0, 1'b1, 1'b1}, 16};
        vecs[2] = '{3'd7, 1'b0, 1'b0, 4'd0,  32'h0000_0001, 1'b0, '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1}, 17};
        vecs[3] = '{3'd2, 1'b1, 1'b0, 4'd3,  32'h0000_0000, 1'b1, '{32'h0000_0004, 1'b0, 1'b0, 1'b0, 1'b0}, 4};
        vecs[4] = '{3'd3, 1'b1, 1'b0, 4'd1,  32'h0000_0001, 1'b0, '{32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1}, 2};
        vecs[5] = '{3'd1, 1'b0, 1'b0, 4'd1,  32'h0000_0001, 1'b0, '{32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0}, 2};
        vecs[6] = '{3'd4, 1'b0, 1'b1, 4'd2,  32'hABCD_4001, 1'b0, '{32'hABCD_0004, 1'b1, 1'b0, 1'b0, 1'b0}, 3};
        vecs[7] = '{3'd6, 1'b1, 1'b1, 4'd1,  32'hFFFF_FF80, 1'b0, '{32'hFFFF_FF00, 1'b1, 1'b1, 1'b0, 1'b1}, 2};

        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, sh.busy}, 32'd0);
        check("reset_done", {31'd0, sh.done}, 32'd0);
        check_res("reset", '{32'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        rst = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].op, vecs[i].bs, vecs[i].ws, vecs[i].cnt, vecs[i].op0,
                   vecs[i].cin, vecs[i].exp, vecs[i].lat);

        for (int i = 0; i < 60; i++) begin
            ro  = 3'($urandom_range(0, 7));
            rb  = 1'($urandom_range(0, 1));
            rw  = 1'($urandom_range(0, 1));
            rk  = 4'($urandom_range(0, 15));
            rx  = $urandom;
            rci = 1'($urandom_range(0, 1));
            e   = model(ro, rb, rw, rk, rx, rci);
            run_op(ro, rb, rw, rk, rx, rci, e, (rk == 4'd0) ? 17 : int'(rk) + 1);
        end

        // second start while busy must not disturb the running operation
        e = model(3'd0, 1'b0, 1'b0, 4'd8, 32'h8000_0001, 1'b0);
        start_op(3'd0, 1'b0, 1'b0, 4'd8, 32'h8000_0001, 1'b0);
        sh.op    = 3'd7;
        sh.op0   = 32'h0000_FFFF;
        sh.cnt   = 4'd1;
        sh.start = 1'b1;
        @(negedge clk);
        sh.start = 1'b0;
        @(negedge clk);
        wait_done(2, lat, bcyc);
        $display("start-while-busy: rslt=%08h c=%0d lat=%0d", sh.rslt, sh.c, lat);
        check_res("busy_ignore", e);
        check("busy_ignore_lat", 32'(lat), 32'd9);
        @(negedge clk);

        // cen low for 5 cycles mid-run stretches latency by exactly 5
        e = model(3'd7, 1'b0, 1'b0, 4'd4, 32'h0000_00F0, 1'b0);
        start_op(3'd7, 1'b0, 1'b0, 4'd4, 32'h0000_00F0, 1'b0);
        @(negedge clk);
        cen = 1'b0;
        repeat (5) @(negedge clk);
        cen = 1'b1;
        wait_done(6, lat, bcyc);
        $display("cen-stall: rslt=%08h c=%0d lat=%0d", sh.rslt, sh.c, lat);
        check_res("cen_stall", e);
        check("cen_stall_lat", 32'(lat), 32'd10);
        cen = 1'b0;
        repeat (3) @(negedge clk);
        check("done_stretch", {31'd0, sh.done}, 32'd1);
        cen = 1'b1;
        @(negedge clk);
        check("done_release", {31'd0, sh.done}, 32'd0);

        // reset mid-run aborts at once, then a fresh operation runs normally
        start_op(3'd2, 1'b0, 1'b0, 4'd0, 32'h1234_5678, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        $display("reset-abort: busy=%0d rslt=%08h", sh.busy, sh.rslt);
        check("abort_busy", {31'd0, sh.busy}, 32'd0);
        check("abort_rslt", sh.rslt, 32'd0);
        check("abort_c", {31'd0, sh.c}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        e = model(3'd3, 1'b1, 1'b0, 4'd1, 32'h0000_0001, 1'b0);
        run_op(3'd3, 1'b1, 1'b0, 4'd1, 32'h0000_0001, 1'b0, e, 2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
